// File: rtl/y_line_fetch.sv
// Y line fetch: turns a decoded line-address pair into two SRAM reads and
// presents both captured lines as one valid/ready output beat.
module y_line_fetch #(
   parameter int                ADDR_W    = 11,
   parameter int                DATA_W    = 256,
   parameter logic [ADDR_W-1:0] NULL_ADDR = {ADDR_W{1'b1}}
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] yLF_addr1,
   input  logic [ADDR_W-1:0] yLF_addr2,
   input  logic              yLF_reqValid,
   output logic              yLF_memRdEn,
   output logic [ADDR_W-1:0] yLF_memAddr,
   input  logic [DATA_W-1:0] yLF_memRdData,
   output logic [DATA_W-1:0] yLF_line1,
   output logic [DATA_W-1:0] yLF_line2,
   output logic              yLF_line2Valid,
   output logic              yLF_outValid,
   input  logic              yLF_outReady,
   output logic              yLF_busy,
   output logic              yLF_overflow
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE1,
      S_ISSUE2,
      S_CAP2,
      S_OUT
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_a1;
   logic [ADDR_W-1:0] r_a2;
   logic [ADDR_W-1:0] r_pend_a1;
   logic [ADDR_W-1:0] r_pend_a2;
   logic [ADDR_W-1:0] w_ld_a1;
   logic [ADDR_W-1:0] w_ld_a2;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_rd_en;
   logic              r_pend_vld;
   logic              r_line2_vld;
   logic              r_out_vld;
   logic              r_ovf;
   logic [DATA_W-1:0] r_line1;
   logic [DATA_W-1:0] r_line2;
   logic              w_req;
   logic              w_hs;
   logic              w_free;
   logic              w_load;
   logic              w_pend_wr;
   logic              w_pend_clr;
   logic              w_ovf_set;

   // addr1 == NULL_ADDR is the decoder's idle pattern, not a request
   assign w_req  = yLF_reqValid && (yLF_addr1 != NULL_ADDR);
   assign w_hs   = r_out_vld && yLF_outReady;
   assign w_free = (r_state == S_IDLE) || ((r_state == S_OUT) && w_hs);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_ld_a1     = r_a1;
      w_ld_a2     = r_a2;
      w_pend_wr   = 1'b0;
      w_pend_clr  = 1'b0;
      w_ovf_set   = 1'b0;

      case (r_state)
         S_ISSUE1: w_state_nxt = S_ISSUE2;
         S_ISSUE2: w_state_nxt = S_CAP2;
         S_CAP2:   w_state_nxt = S_OUT;
         S_OUT:    if (w_hs) w_state_nxt = S_IDLE;
         default:  w_state_nxt = r_state;
      endcase

      // Pending always wins a free slot; a same-cycle request refills it
      if (w_free) begin
         if (r_pend_vld) begin
            w_load      = 1'b1;
            w_ld_a1     = r_pend_a1;
            w_ld_a2     = r_pend_a2;
            w_state_nxt = S_ISSUE1;
            if (w_req) begin
               w_pend_wr = 1'b1;
            end else begin
               w_pend_clr = 1'b1;
            end
         end else if (w_req) begin
            w_load      = 1'b1;
            w_ld_a1     = yLF_addr1;
            w_ld_a2     = yLF_addr2;
            w_state_nxt = S_ISSUE1;
         end
      end else if (w_req) begin
         if (!r_pend_vld) begin
            w_pend_wr = 1'b1;
         end else begin
            w_ovf_set = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_load) begin
         r_a1 <= w_ld_a1;
         r_a2 <= w_ld_a2;
      end
      if (w_pend_wr) begin
         r_pend_a1 <= yLF_addr1;
         r_pend_a2 <= yLF_addr2;
      end
   end

   // Read strobe/address are registered from the state being entered
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mem_rd_en <= 1'b0;
         r_mem_addr  <= NULL_ADDR;
         r_pend_vld  <= 1'b0;
         r_ovf       <= 1'b0;
         r_line1     <= '0;
         r_line2     <= '0;
         r_line2_vld <= 1'b0;
         r_out_vld   <= 1'b0;
      end else begin
         case (w_state_nxt)
            S_ISSUE1: begin
               r_mem_rd_en <= 1'b1;
               r_mem_addr  <= w_ld_a1;
            end
            S_ISSUE2: begin
               r_mem_rd_en <= (r_a2 != NULL_ADDR);
               r_mem_addr  <= r_a2;
            end
            default: begin
               r_mem_rd_en <= 1'b0;
               r_mem_addr  <= NULL_ADDR;
            end
         endcase

         if (w_pend_wr) begin
            r_pend_vld <= 1'b1;
         end else if (w_pend_clr) begin
            r_pend_vld <= 1'b0;
         end

         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end

         if (r_state == S_ISSUE2) begin
            r_line1 <= yLF_memRdData;
         end

         if (r_state == S_CAP2) begin
            r_out_vld <= 1'b1;
            if (r_a2 != NULL_ADDR) begin
               r_line2     <= yLF_memRdData;
               r_line2_vld <= 1'b1;
            end else begin
               r_line2     <= '0;
               r_line2_vld <= 1'b0;
            end
         end else if ((r_state == S_OUT) && w_hs) begin
            r_out_vld <= 1'b0;
         end
      end
   end

   assign yLF_memRdEn    = r_mem_rd_en;
   assign yLF_memAddr    = r_mem_addr;
   assign yLF_line1      = r_line1;
   assign yLF_line2      = r_line2;
   assign yLF_line2Valid = r_line2_vld;
   assign yLF_outValid   = r_out_vld;
   assign yLF_busy       = r_pend_vld;
   assign yLF_overflow   = r_ovf;

endmodule
